evm_param_ballot_unit: RTL

//  Parametrised next-generation EVM voting core: N-party ballot FSM, one-vote-per-ID registry,

---
 rtl/evm_param_ballot_unit_if.sv | 36 +++
 rtl/evm_param_ballot_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/evm_param_ballot_unit_if.sv
// Bundles the ballot unit's control inputs and status/result outputs.
// The master side drives voter and officer inputs; the slave side is the voting core.
interface evm_param_ballot_unit_if #(
  parameter int NUM_PARTIES = 8,
  parameter int ID_WIDTH    = 5,
  parameter int COUNT_WIDTH = 8
);
  localparam int SEL_W = $clog2(NUM_PARTIES);

  logic                         session_clear;
  logic                         mode;
  logic                         voter_valid;
  logic [ID_WIDTH-1:0]          voter_id;
  logic [NUM_PARTIES-1:0]       push;
  logic [SEL_W-1:0]             party_sel;
  logic                         status_led;
  logic                         vote_accept;
  logic                         vote_reject;
  logic [COUNT_WIDTH-1:0]       result_count;
  logic [SEL_W-1:0]             winner;
  logic                         tie;
  logic [COUNT_WIDTH+SEL_W-1:0] total_votes;
  logic                         overflow;

  modport master (
    output session_clear, mode, voter_valid, voter_id, push, party_sel,
    input  status_led, vote_accept, vote_reject, result_count, winner, tie,
           total_votes, overflow
  );

  modport slave (
    input  session_clear, mode, voter_valid, voter_id, push, party_sel,
    output status_led, vote_accept, vote_reject, result_count, winner, tie,
           total_votes, overflow
  );
endinterface

// File: rtl/evm_param_ballot_unit.sv
// N-party EVM voting core: ballot FSM, one-vote-per-ID registry, saturating
// per-party counters, registered winner/tie detection and result readout.
module evm_param_ballot_unit #(
  parameter int NUM_PARTIES  = 8,
  parameter int ID_WIDTH     = 5,
  parameter int COUNT_WIDTH  = 8,
  parameter int VOTE_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  evm_param_ballot_unit_if.slave  bus
);
  localparam int SEL_W   = $clog2(NUM_PARTIES);
  localparam int TOT_W   = COUNT_WIDTH + SEL_W;
  localparam int TMR_W   = $clog2(VOTE_TIMEOUT + 1);
  localparam int NUM_IDS = 2 ** ID_WIDTH;
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [TMR_W-1:0]       TMR_LAST = TMR_W'(VOTE_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BALLOT, S_RELEASE} state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [ID_WIDTH-1:0]    r_id;
  logic [TMR_W-1:0]       r_timer;
  logic [NUM_IDS-1:0]     r_voted;
  logic [COUNT_WIDTH-1:0] r_count [NUM_PARTIES];
  logic [TOT_W-1:0]       r_total;
  logic                   r_overflow;
  logic                   r_accept;
  logic                   r_reject;
  logic [SEL_W-1:0]       r_winner;
  logic                   r_tie;

  logic                   w_onehot;
  logic [SEL_W-1:0]       w_pushIdx;
  logic                   w_latch;
  logic                   w_vote;
  logic                   w_reject;
  logic [SEL_W-1:0]       w_winner;
  logic [COUNT_WIDTH-1:0] w_best;
  logic                   w_tie;
  logic [COUNT_WIDTH-1:0] w_result;

  always_comb begin
    w_onehot  = $onehot(bus.push);
    w_pushIdx = '0;
    for (int i = 0; i < NUM_PARTIES; i++) begin
      if (bus.push[i]) w_pushIdx = SEL_W'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // An abort via mode takes precedence over a push landing in the same cycle.
  always_comb begin
    w_next   = r_state;
    w_latch  = 1'b0;
    w_vote   = 1'b0;
    w_reject = 1'b0;
    if (bus.session_clear) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.voter_valid) begin
            if (bus.mode || r_voted[bus.voter_id]) begin
              w_reject = 1'b1;
            end else begin
              w_latch = 1'b1;
              w_next  = S_BALLOT;
            end
          end
        end
        S_BALLOT: begin
          if (bus.mode) begin
            w_reject = 1'b1;
            w_next   = S_IDLE;
          end else if (w_onehot) begin
            w_vote = 1'b1;
            w_next = S_RELEASE;
          end else if (r_timer == TMR_LAST) begin
            w_reject = 1'b1;
            w_next   = S_IDLE;
          end
        end
        S_RELEASE: begin
          if (bus.push == '0) w_next = S_IDLE;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Lowest index wins on equal counts, so only a strictly greater count moves the winner.
  always_comb begin
    w_winner = '0;
    w_best   = r_count[0];
    for (int i = 1; i < NUM_PARTIES; i++) begin
      if (r_count[i] > w_best) begin
        w_best   = r_count[i];
        w_winner = SEL_W'(i);
      end
    end
    w_tie = 1'b0;
    for (int i = 0; i < NUM_PARTIES; i++) begin
      if ((SEL_W'(i) != w_winner) && (r_count[i] == w_best) && (w_best != '0)) w_tie = 1'b1;
    end
  end

  always_comb begin
    w_result = '0;
    if (bus.mode) begin
      for (int i = 0; i < NUM_PARTIES; i++) begin
        if (bus.party_sel == SEL_W'(i)) w_result = r_count[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_id       <= '0;
      r_timer    <= '0;
      r_voted    <= '0;
      r_total    <= '0;
      r_overflow <= 1'b0;
      r_accept   <= 1'b0;
      r_reject   <= 1'b0;
      r_winner   <= '0;
      r_tie      <= 1'b0;
      for (int i = 0; i < NUM_PARTIES; i++) r_count[i] <= '0;
    end else begin
      r_accept <= w_vote;
      r_reject <= w_reject;
      r_winner <= w_winner;
      r_tie    <= w_tie;
      if (w_latch) begin
        r_id    <= bus.voter_id;
        r_timer <= '0;
      end else if (r_state == S_BALLOT) begin
        r_timer <= r_timer + TMR_W'(1);
      end
      if (bus.session_clear) begin
        r_voted    <= '0;
        r_total    <= '0;
        r_overflow <= 1'b0;
        for (int i = 0; i < NUM_PARTIES; i++) r_count[i] <= '0;
      end else if (w_vote) begin
        r_voted[r_id] <= 1'b1;
        // A saturated counter still consumes the voter's ID but flags the lost vote.
        if (r_count[w_pushIdx] == CNT_MAX) begin
          r_overflow <= 1'b1;
        end else begin
          r_count[w_pushIdx] <= r_count[w_pushIdx] + COUNT_WIDTH'(1);
          r_total            <= r_total + TOT_W'(1);
        end
      end
    end
  end

  assign bus.status_led   = (r_state == S_BALLOT);
  assign bus.vote_accept  = r_accept;
  assign bus.vote_reject  = r_reject;
  assign bus.result_count = w_result;
  assign bus.winner       = r_winner;
  assign bus.tie          = r_tie;
  assign bus.total_votes  = r_total;
  assign bus.overflow     = r_overflow;
endmodule
